// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: zeroes the register file after reset, then merges
// pipeline writebacks with buffered long-latency (mul/div) results through a small FIFO.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [ADDR_WIDTH-1:0]    wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [ADDR_WIDTH-1:0]    mdu_rd,
    input  logic [DATA_WIDTH-1:0]    mdu_data,
    output logic                     we3,
    output logic [ADDR_WIDTH-1:0]    ad3,
    output logic [DATA_WIDTH-1:0]    wd3,
    output logic                     busy,
    output logic [2**ADDR_WIDTH-1:0] pending
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   counter, counter_next;
    logic [ADDR_WIDTH-1:0]   fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]        head, tail;
    logic [CNT_W-1:0]        count;
    logic                    fifo_empty;
    logic                    wb_hit;
    logic                    push;
    logic                    pop;

    assign fifo_empty = (count == '0);
    assign wb_hit     = wb_we && (wb_rd != '0);

    always_comb begin
        state_next   = state;
        counter_next = counter;
        busy         = 1'b1;
        mdu_ready    = 1'b0;
        case (state)
            INIT: begin
                if (counter == LAST_REG)
                    state_next = RUN;
                else
                    counter_next = counter + ADDR_WIDTH'(1);
            end
            RUN: begin
                busy      = 1'b0;
                mdu_ready = (count < FULL_CNT);
            end
            default: state_next = INIT;
        endcase
        if (rst) begin
            busy      = 1'b1;
            mdu_ready = 1'b0;
        end
    end

    // Results for x0 complete the handshake but are dropped instead of occupying a slot.
    assign push = mdu_valid && mdu_ready && (mdu_rd != '0);

    always_comb begin
        we3 = 1'b0;
        ad3 = '0;
        wd3 = '0;
        pop = 1'b0;
        if (!rst) begin
            if (state == INIT) begin
                we3 = 1'b1;
                ad3 = counter;
            end else if (wb_hit) begin
                we3 = 1'b1;
                ad3 = wb_rd;
                wd3 = wb_data;
            end else if (!fifo_empty) begin
                we3 = 1'b1;
                ad3 = fifo_rd[head];
                wd3 = fifo_data[head];
                pop = 1'b1;
            end
        end
    end

    // Scan only the occupied slots, walking forward from the head.
    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < count)
                pending[fifo_rd[head + PTR_W'(i)]] = 1'b1;
        end
        pending[0] = 1'b0;
        if (rst)
            pending = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            counter <= ADDR_WIDTH'(1);
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= mdu_rd;
            fifo_data[tail] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: expected register writes are queued as stimulus is
// driven and a negedge monitor pops and compares every write the DUT issues in RUN.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        we3;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic        busy;
    logic [31:0] pending;

    typedef struct {
        logic [4:0]  ad;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  sb_on  = 1'b0;

    regfile_wb_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .FIFO_DEPTH(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .mdu_valid(mdu_valid),
        .mdu_ready(mdu_ready),
        .mdu_rd   (mdu_rd),
        .mdu_data (mdu_data),
        .we3      (we3),
        .ad3      (ad3),
        .wd3      (wd3),
        .busy     (busy),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // Every write seen in RUN must be the next queued expectation.
    always @(negedge clk) begin
        if (sb_on) begin
            checks++;
            if (we3) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: got ad3=%0d wd3=%h, expected no write", ad3, wd3);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (ad3 !== e.ad || wd3 !== e.wd) begin
                        errors++;
                        $display("[TB] FAIL write_port: got ad3=%0d wd3=%h, expected ad3=%0d wd3=%h",
                                 ad3, wd3, e.ad, e.wd);
                    end
                end
            end else if (ad3 !== 5'd0 || wd3 !== 32'd0) begin
                errors++;
                $display("[TB] FAIL idle_port_zero: got ad3=%0d wd3=%h, expected 0/0", ad3, wd3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] ad, input logic [31:0] wd);
        wr_t e;
        e.ad = ad;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        mdu_valid = 1'b0;
        mdu_rd    = 5'd0;
        mdu_data  = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (we3 !== 1'b0 || ad3 !== 5'd0 || wd3 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_port: got we3=%b ad3=%0d wd3=%h, expected 0/0/0", we3, ad3, wd3);
        end
        checks++;
        if (busy !== 1'b1 || mdu_ready !== 1'b0 || pending !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: got busy=%b mdu_ready=%b pending=%h, expected 1/0/0",
                     busy, mdu_ready, pending);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_init();
        wb_we     = 1'b1;
        wb_rd     = 5'd7;
        wb_data   = 32'h1234_5678;
        mdu_valid = 1'b1;
        mdu_rd    = 5'd9;
        mdu_data  = 32'h9999_9999;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            checks++;
            if (we3 !== 1'b1 || ad3 !== 5'(k) || wd3 !== 32'd0 || busy !== 1'b1 || mdu_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL init_write_%0d: got we3=%b ad3=%0d wd3=%h busy=%b rdy=%b, expected 1/%0d/0/1/0",
                         k, we3, ad3, wd3, busy, mdu_ready, k);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mdu_ready !== 1'b1 || we3 !== 1'b0 || pending !== 32'd0) begin
            errors++;
            $display("[TB] FAIL init_done: got busy=%b rdy=%b we3=%b pending=%h, expected 0/1/0/0",
                     busy, mdu_ready, we3, pending);
        end
        sb_on = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        mdu_valid = 1'b1;
        mdu_rd    = 5'd5;
        mdu_data  = 32'h0000_DEAD;
        expect_write(5'd5, 32'h0000_DEAD);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b1 || pending !== 32'd0 || we3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL push_cycle: got rdy=%b pending=%h we3=%b, expected 1/0/0", mdu_ready, pending, we3);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (pending !== 32'h0000_0020) begin
            errors++;
            $display("[TB] FAIL pending_5_set: got %h, expected 00000020", pending);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pending !== 32'd0 || we3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pending_5_clear: got pending=%h we3=%b, expected 0/0", pending, we3);
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_drain: got %0d outstanding writes, expected 0", exp_q.size());
        end
    endtask

    task automatic test_wb_priority();
        wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'hA10;
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h33;
        expect_write(5'd10, 32'hA10);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_ready_a: got %b, expected 1", mdu_ready);
        end
        tick();
        wb_rd = 5'd11; wb_data = 32'hA11;
        mdu_rd = 5'd4; mdu_data = 32'h44;
        expect_write(5'd11, 32'hA11);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b1 || pending !== 32'h0000_0008) begin
            errors++;
            $display("[TB] FAIL prio_b: got rdy=%b pending=%h, expected 1/00000008", mdu_ready, pending);
        end
        tick();
        wb_rd = 5'd12; wb_data = 32'hA12;
        mdu_rd = 5'd9; mdu_data = 32'h99;
        expect_write(5'd12, 32'hA12);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b0 || pending !== 32'h0000_0018) begin
            errors++;
            $display("[TB] FAIL prio_full: got rdy=%b pending=%h, expected 0/00000018", mdu_ready, pending);
        end
        tick();
        mdu_valid = 1'b0;
        wb_rd = 5'd13; wb_data = 32'hA13;
        expect_write(5'd13, 32'hA13);
        @(negedge clk);
        checks++;
        if (pending !== 32'h0000_0018) begin
            errors++;
            $display("[TB] FAIL prio_hold: got pending=%h, expected 00000018", pending);
        end
        tick();
        idle_inputs();
        expect_write(5'd3, 32'h33);
        expect_write(5'd4, 32'h44);
        @(negedge clk);
        checks++;
        if (pending !== 32'h0000_0018) begin
            errors++;
            $display("[TB] FAIL drain_first: got pending=%h, expected 00000018", pending);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pending !== 32'h0000_0010) begin
            errors++;
            $display("[TB] FAIL drain_second: got pending=%h, expected 00000010", pending);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pending !== 32'd0 || we3 !== 1'b0 || mdu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_done: got pending=%h we3=%b rdy=%b, expected 0/0/1", pending, we3, mdu_ready);
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL prio_drain: got %0d outstanding writes, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'hB20;
        mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
        expect_write(5'd20, 32'hB20);
        tick();
        wb_rd = 5'd21; wb_data = 32'hB21;
        mdu_rd = 5'd7; mdu_data = 32'h77;
        expect_write(5'd21, 32'hB21);
        expect_write(5'd6, 32'h66);
        expect_write(5'd7, 32'h77);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b1 || pending !== 32'h0000_0040) begin
            errors++;
            $display("[TB] FAIL b2b_fill: got rdy=%b pending=%h, expected 1/00000040", mdu_ready, pending);
        end
        tick();
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        mdu_rd = 5'd8; mdu_data = 32'h88;
        expect_write(5'd8, 32'h88);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b0 || pending !== 32'h0000_00C0) begin
            errors++;
            $display("[TB] FAIL b2b_full: got rdy=%b pending=%h, expected 0/000000c0", mdu_ready, pending);
        end
        tick();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if (mdu_ready !== 1'b1 || pending !== (32'd1 << (7 + n))) begin
                errors++;
                $display("[TB] FAIL b2b_stream_%0d: got rdy=%b pending=%h, expected 1/%h",
                         n, mdu_ready, pending, 32'd1 << (7 + n));
            end
            tick();
            if (n < 3) begin
                mdu_rd   = 5'(9 + n);
                mdu_data = 32'h90 + 32'(n);
                expect_write(5'(9 + n), 32'h90 + 32'(n));
            end
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (pending !== 32'h0000_0800) begin
            errors++;
            $display("[TB] FAIL b2b_last: got pending=%h, expected 00000800", pending);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pending !== 32'd0 || we3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_empty: got pending=%h we3=%b, expected 0/0", pending, we3);
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got %0d outstanding writes, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reg_zero();
        wb_we = 1'b1; wb_rd = 5'd15; wb_data = 32'hF15;
        mdu_valid = 1'b1; mdu_rd = 5'd14; mdu_data = 32'hE14;
        expect_write(5'd15, 32'hF15);
        tick();
        wb_rd = 5'd0; wb_data = 32'h0000_BEEF;
        mdu_rd = 5'd0; mdu_data = 32'h0000_0BAD;
        expect_write(5'd14, 32'hE14);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b1 || pending !== 32'h0000_4000) begin
            errors++;
            $display("[TB] FAIL x0_cycle: got rdy=%b pending=%h, expected 1/00004000", mdu_ready, pending);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (pending !== 32'd0 || we3 !== 1'b0 || mdu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL x0_after: got pending=%h we3=%b rdy=%b, expected 0/0/1", pending, we3, mdu_ready);
        end
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL x0_drain: got %0d outstanding writes, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_flush();
        wb_we = 1'b1; wb_rd = 5'd18; wb_data = 32'hC18;
        mdu_valid = 1'b1; mdu_rd = 5'd16; mdu_data = 32'h160;
        expect_write(5'd18, 32'hC18);
        tick();
        wb_rd = 5'd19; wb_data = 32'hC19;
        mdu_rd = 5'd17; mdu_data = 32'h170;
        expect_write(5'd19, 32'hC19);
        tick();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pending !== 32'd0 || busy !== 1'b1 || mdu_ready !== 1'b0 || we3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_in_reset: got pending=%h busy=%b rdy=%b we3=%b, expected 0/1/0/0",
                     pending, busy, mdu_ready, we3);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL flush_pre_drain: got %0d outstanding writes, expected 0", exp_q.size());
        end
        tick();
        rst   = 1'b0;
        sb_on = 1'b0;
        test_init();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (we3 !== 1'b0 || pending !== 32'd0) begin
                errors++;
                $display("[TB] FAIL flush_lost_%0d: got we3=%b ad3=%0d pending=%h, expected 0/-/0",
                         c, we3, ad3, pending);
            end
            tick();
        end
    endtask

    initial begin
        $display("[TB] starting regfile_wb_arbiter bench");
        test_reset();
        test_init();
        test_single_push();
        test_wb_priority();
        test_back_to_back();
        test_reg_zero();
        test_reset_flush();
        sb_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
